// File: rtl/mat_row_streamer.sv
// Captures an NxN row-major matrix from a load stream and replays it on demand
// as N rows of N elements, tlast on each row's final element.
module mat_row_streamer #(
  parameter int N  = 2,
  parameter int DW = 32
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  input  logic          start,
  input  logic          clear,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  output logic          mat_loaded,
  output logic          busy,
  output logic          done,
  output logic          load_err
);
  localparam int DEPTH = N * N;
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

  typedef enum logic [1:0] {S_LOAD, S_READY, S_STREAM} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          wr_en;

  logic [DW-1:0] mem [DEPTH];

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    row_d    = row_q;
    col_d    = col_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (s_axis_tvalid) begin
          wr_en = 1'b1;
          if (s_axis_tlast && wr_idx_q == LAST_IDX) begin
            state_d  = S_READY;
            wr_idx_d = '0;
          end else if (s_axis_tlast || wr_idx_q == LAST_IDX) begin
            // Misframed matrix: restart capture so the next beat is element 0.
            err_d    = 1'b1;
            wr_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end
      end
      S_READY: begin
        if (start) begin
          state_d  = S_STREAM;
          rd_idx_d = '0;
          row_d    = '0;
          col_d    = '0;
        end else if (clear) begin
          state_d = S_LOAD;
        end
      end
      S_STREAM: begin
        if (!tvalid_q) begin
          // First cycle of a replay fills the output register with element 0.
          tvalid_d = 1'b1;
          tdata_d  = mem[rd_idx_q];
        end else if (m_axis_tready) begin
          if (rd_idx_q == LAST_IDX) begin
            tvalid_d = 1'b0;
            done_d   = 1'b1;
            state_d  = S_READY;
            rd_idx_d = '0;
            row_d    = '0;
            col_d    = '0;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + CW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            tdata_d = mem[rd_idx_d];
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately left out of reset; mat_loaded qualifies it.
  always_ff @(posedge aclk) begin
    if (wr_en && !areset) mem[wr_idx_q] <= s_axis_tdata;
  end

  assign s_axis_tready = (state_q == S_LOAD);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q && (col_q == LAST_COL);
  assign mat_loaded    = (state_q == S_READY) || (state_q == S_STREAM);
  assign busy          = (state_q == S_STREAM);
  assign done          = done_q;
  assign load_err      = err_q;
endmodule
